// File: rtl/ctrl_pkg.sv
// Shared constants for the accumulator CPU control unit: opcodes, FSM states,
// control-word bit positions and ALU operation codes.
package ctrl_pkg;

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpSta = 4'h2;
    localparam logic [3:0] OpAdd = 4'h3;
    localparam logic [3:0] OpSub = 4'h4;
    localparam logic [3:0] OpJmp = 4'h5;
    localparam logic [3:0] OpJz  = 4'h6;
    localparam logic [3:0] OpJc  = 4'h7;
    localparam logic [3:0] OpHlt = 4'hF;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam int unsigned CwPcInc   = 0;
    localparam int unsigned CwIrLoad  = 1;
    localparam int unsigned CwMemRd   = 2;
    localparam int unsigned CwMemWr   = 3;
    localparam int unsigned CwAccLoad = 4;
    localparam int unsigned CwPcLoad  = 5;
    localparam int unsigned CwAluLo   = 6;

    localparam logic [1:0] AluPass = 2'b00;
    localparam logic [1:0] AluAdd  = 2'b01;
    localparam logic [1:0] AluSub  = 2'b10;

    function automatic logic [1:0] alu_sel(input logic [3:0] op);
        unique case (op)
            OpAdd:   alu_sel = AluAdd;
            OpSub:   alu_sel = AluSub;
            default: alu_sel = AluPass;
        endcase
    endfunction

endpackage

// File: rtl/tt_um_eemukh_control_block_if.sv
// TinyTapeout pin bundle for the control tile; slave is the tile side,
// master is the surrounding datapath/memory side.
interface tt_um_eemukh_control_block_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational decode: (state, ir, Z, C) -> control word, jump_taken and
// next state. IDLE holds here; the run qualification lives in the top.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [3:0] ir,
    input  logic       z,
    input  logic       c,
    output logic [7:0] ctrl,
    output logic       jump_taken,
    output state_e     next_state
);

    always_comb begin
        ctrl       = '0;
        jump_taken = 1'b0;
        next_state = state;
        case (state)
            StIdle: next_state = StIdle;
            StFetch: begin
                ctrl[CwPcInc]  = 1'b1;
                ctrl[CwIrLoad] = 1'b1;
                ctrl[CwMemRd]  = 1'b1;
                next_state     = StDecode;
            end
            StDecode: next_state = (ir == OpHlt) ? StHalt : StExec;
            StExec: begin
                next_state = StFetch;
                case (ir)
                    OpLda, OpAdd, OpSub: begin
                        ctrl[CwMemRd] = 1'b1;
                        next_state    = StWb;
                    end
                    OpSta: ctrl[CwMemWr] = 1'b1;
                    OpJmp: begin
                        ctrl[CwMemRd]  = 1'b1;
                        ctrl[CwPcLoad] = 1'b1;
                    end
                    // Conditional jumps follow the live flags (Mealy output).
                    OpJz: begin
                        ctrl[CwMemRd]  = 1'b1;
                        ctrl[CwPcLoad] = z;
                    end
                    OpJc: begin
                        ctrl[CwMemRd]  = 1'b1;
                        ctrl[CwPcLoad] = c;
                    end
                    default: ;
                endcase
                jump_taken = ctrl[CwPcLoad];
            end
            StWb: begin
                ctrl[CwAccLoad]       = 1'b1;
                ctrl[CwAluLo +: 2]    = alu_sel(ir);
                next_state            = StFetch;
            end
            StHalt:  next_state = StHalt;
            default: next_state = StIdle;
        endcase
    end

endmodule

// File: rtl/tt_um_eemukh_control_block.sv
// Multi-cycle control unit tile: state/pc/ir registers, run and ena handling,
// and output gating around the ctrl_decode map.
module tt_um_eemukh_control_block
    import ctrl_pkg::*;
(
    input logic                          clk,
    input logic                          rst_n,
    input logic                          ena,
    tt_um_eemukh_control_block_if.slave  bus
);

    state_e     state_q, state_d, dec_next;
    logic [3:0] pc_q, pc_d;
    logic [3:0] ir_q, ir_d;
    logic [7:0] ctrl;
    logic       jump_taken;
    logic       run;
    logic       unused_uio;

    assign run        = bus.uio_in[2];
    assign unused_uio = ^bus.uio_in[7:3];

    ctrl_decode u_decode (
        .state      (state_q),
        .ir         (ir_q),
        .z          (bus.uio_in[0]),
        .c          (bus.uio_in[1]),
        .ctrl       (ctrl),
        .jump_taken (jump_taken),
        .next_state (dec_next)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (ena) begin
            state_d = dec_next;
            if (state_q == StIdle && run) begin
                state_d = StFetch;
            end
            if (state_q == StFetch) begin
                ir_d = bus.ui_in[7:4];
                pc_d = pc_q + 4'd1;
            end
            // A taken jump replaces the increment made during FETCH.
            if (jump_taken) begin
                pc_d = bus.ui_in[3:0];
            end
        end
    end

    // rst_n keeps its pin name but is active-high.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= StIdle;
            pc_q    <= 4'h0;
            ir_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.uo_out  = ena ? ctrl : 8'h00;
    assign bus.uio_out = {pc_q, ena && (state_q == StHalt), 3'b000};
    assign bus.uio_oe  = 8'hF8;

endmodule

// File: tb/tb_tt_um_eemukh_control_block.sv
// Directed bench for the control tile: a cycle-by-cycle vector table for the
// instruction flow plus hand sequences for halt hold, idle and pc wrap.
module tb_tt_um_eemukh_control_block;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    tt_um_eemukh_control_block_if bus ();

    tt_um_eemukh_control_block dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] ui;
        logic [7:0] uio;
        logic       chk;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic add(input logic r, input logic e, input logic [7:0] ui,
                       input logic [7:0] uio, input logic k, input logic [7:0] uo,
                       input logic [7:0] uo2);
        vec_t v;
        v = '{r, e, ui, uio, k, uo, uo2};
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] uo, input logic [7:0] uo2);
        check({tag, " uo_out"}, bus.uo_out, uo);
        check({tag, " uio_out"}, bus.uio_out, uo2);
        check({tag, " uio_oe"}, bus.uio_oe, 8'hF8);
    endtask

    initial begin
        // rst ena ui uio chk uo uio_out ; expectations are for the state before the edge
        add(1, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        add(1, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00); // IDLE after reset
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00);
        add(0, 1, 8'h00, 8'h04, 1, 8'h00, 8'h00); // run sampled
        add(0, 1, 8'h10, 8'h00, 1, 8'h07, 8'h00); // FETCH LDA
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h10);
        add(0, 1, 8'h00, 8'h00, 1, 8'h04, 8'h10);
        add(0, 1, 8'h00, 8'h00, 1, 8'h10, 8'h10); // WB LDA
        add(0, 1, 8'h40, 8'h00, 1, 8'h07, 8'h10); // FETCH SUB
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h20);
        add(0, 1, 8'h00, 8'h00, 1, 8'h04, 8'h20);
        add(0, 1, 8'h00, 8'h00, 1, 8'h90, 8'h20); // WB SUB
        add(0, 1, 8'h60, 8'h00, 1, 8'h07, 8'h20); // FETCH JZ
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h30);
        add(0, 1, 8'h09, 8'h00, 1, 8'h04, 8'h30); // JZ not taken
        add(0, 1, 8'h60, 8'h00, 1, 8'h07, 8'h30); // pc = fetch+1
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h40);
        add(0, 1, 8'h09, 8'h01, 1, 8'h24, 8'h40); // JZ taken
        add(0, 1, 8'h20, 8'h00, 1, 8'h07, 8'h90); // FETCH STA at 9
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'hA0);
        add(0, 1, 8'h00, 8'h00, 1, 8'h08, 8'hA0);
        add(0, 1, 8'h30, 8'h00, 1, 8'h07, 8'hA0); // FETCH ADD
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'hB0);
        add(0, 1, 8'h00, 8'h00, 1, 8'h04, 8'hB0);
        add(0, 1, 8'h00, 8'h00, 1, 8'h50, 8'hB0); // WB ADD
        add(0, 1, 8'h70, 8'h00, 1, 8'h07, 8'hB0); // FETCH JC
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'hC0);
        add(0, 1, 8'h05, 8'h01, 1, 8'h04, 8'hC0); // JC with Z only: not taken
        add(0, 1, 8'h70, 8'h00, 1, 8'h07, 8'hC0);
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'hD0);
        add(0, 1, 8'h05, 8'h02, 1, 8'h24, 8'hD0); // JC taken
        add(0, 1, 8'h50, 8'h00, 1, 8'h07, 8'h50); // FETCH JMP at 5
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h60);
        add(0, 1, 8'h0E, 8'h00, 1, 8'h24, 8'h60);
        add(0, 1, 8'h80, 8'h00, 1, 8'h07, 8'hE0); // code 8 as NOP
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'hF0);
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'hF0);
        add(0, 1, 8'h00, 8'h00, 1, 8'h07, 8'hF0); // FETCH at 15
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00); // wrapped
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00);
        add(0, 0, 8'h10, 8'h00, 1, 8'h00, 8'h00); // ena=0 in FETCH
        add(0, 1, 8'h10, 8'h00, 1, 8'h07, 8'h00); // resumes FETCH
        add(0, 1, 8'h00, 8'h03, 1, 8'h00, 8'h10); // flags ignored in DECODE
        add(0, 1, 8'h00, 8'h00, 1, 8'h04, 8'h10);
        add(1, 0, 8'h00, 8'h00, 1, 8'h00, 8'h10); // reset mid-WB, ena=0
        add(0, 1, 8'h00, 8'h04, 1, 8'h00, 8'h00);
        add(0, 1, 8'hF0, 8'h00, 1, 8'h07, 8'h00); // FETCH HLT
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h10);
        add(0, 1, 8'h00, 8'h04, 1, 8'h00, 8'h18); // HALT
        add(0, 0, 8'h00, 8'h04, 1, 8'h00, 8'h10); // halted masked by ena
        add(0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h18);

        foreach (vq[i]) begin
            rst_n       = vq[i].rst;
            ena         = vq[i].en;
            bus.ui_in   = vq[i].ui;
            bus.uio_in  = vq[i].uio;
            #1;
            if (vq[i].chk) check_all($sformatf("row%0d", i), vq[i].exp_uo, vq[i].exp_uio);
            tick();
        end

        // HALT holds through run toggling
        for (int i = 0; i < 20; i++) begin
            bus.uio_in = (i % 2 == 0) ? 8'h04 : 8'h00;
            bus.ui_in  = 8'h10;
            #1;
            check_all($sformatf("halt%0d", i), 8'h00, 8'h18);
            tick();
        end

        // Reset leaves HALT; idle with run=0
        rst_n      = 1'b1;
        bus.uio_in = 8'h00;
        tick();
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_all($sformatf("idle%0d", i), 8'h00, 8'h00);
            tick();
        end

        // 16 NOPs from pc=0 wrap back to 0
        bus.uio_in = 8'h04;
        tick();
        bus.uio_in = 8'h00;
        bus.ui_in  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            #1;
            check_all($sformatf("wrap%0d", i), 8'h07, {i[3:0], 4'h0});
            tick();
            tick();
            tick();
        end
        #1;
        check_all("wrap_end", 8'h07, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
